// File: rtl/dmem_copy_dma.sv
// Word-granular copy engine on the data-memory port: one read cycle, then one write cycle per word.
// Optional fill mode (constant-value writes) is enabled with `define DMA_FILL_EN.
module dmem_copy_dma #(
    parameter int unsigned Abits = 14,
    parameter int unsigned Lbits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [Lbits-1:0] length,
`ifdef DMA_FILL_EN
    input  logic             fill_mode,
    input  logic [31:0]      fill_value,
`endif
    input  logic [31:0]      mem_readdata,
    output logic             busy,
    output logic             done,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_writedata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [Abits-1:0] src_ptr, src_nxt;
    logic [Abits-1:0] dst_ptr, dst_nxt;
    logic [Lbits-1:0] count, count_nxt;
    logic [31:0]      data_reg, data_nxt;
    logic             fill_reg, fill_nxt;
    logic [31:0]      fill_data, fdat_nxt;
    logic             start_fill;
    logic [31:0]      start_fdat;

    logic             busy_nxt, done_nxt, wr_nxt;
    logic [31:0]      addr_nxt, wdata_nxt;

    // Pointer inputs carry more bits than the pointer; the upper part is intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{src_addr[31:Abits], dst_addr[31:Abits]};

`ifdef DMA_FILL_EN
    assign start_fill = fill_mode;
    assign start_fdat = fill_value;
`else
    assign start_fill = 1'b0;
    assign start_fdat = 32'd0;
`endif

    // Next-state logic; outputs are decoded from the next state so they leave flops directly.
    always_comb begin
        state_nxt = state;
        src_nxt   = src_ptr;
        dst_nxt   = dst_ptr;
        count_nxt = count;
        data_nxt  = data_reg;
        fill_nxt  = fill_reg;
        fdat_nxt  = fill_data;
        case (state)
            IDLE: begin
                if (start) begin
                    src_nxt   = src_addr[Abits-1:0];
                    dst_nxt   = dst_addr[Abits-1:0];
                    count_nxt = length;
                    fill_nxt  = start_fill;
                    fdat_nxt  = start_fdat;
                    if (length == Lbits'(0))
                        state_nxt = DONE;
                    else
                        state_nxt = start_fill ? WRITE : READ;
                end
            end
            READ: begin
                data_nxt  = mem_readdata;
                state_nxt = WRITE;
            end
            WRITE: begin
                src_nxt   = src_ptr + Abits'(1);
                dst_nxt   = dst_ptr + Abits'(1);
                count_nxt = count - Lbits'(1);
                if (count == Lbits'(1))
                    state_nxt = DONE;
                else
                    state_nxt = fill_reg ? WRITE : READ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == DONE);
        wr_nxt    = (state_nxt == WRITE);
        addr_nxt  = 32'd0;
        wdata_nxt = 32'd0;
        if (state_nxt == READ) begin
            addr_nxt = 32'(src_nxt);
        end else if (state_nxt == WRITE) begin
            addr_nxt  = 32'(dst_nxt);
            wdata_nxt = fill_nxt ? fdat_nxt : data_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            src_ptr       <= '0;
            dst_ptr       <= '0;
            count         <= '0;
            data_reg      <= '0;
            fill_reg      <= 1'b0;
            fill_data     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_wr        <= 1'b0;
            mem_addr      <= '0;
            mem_writedata <= '0;
        end else begin
            state         <= state_nxt;
            src_ptr       <= src_nxt;
            dst_ptr       <= dst_nxt;
            count         <= count_nxt;
            data_reg      <= data_nxt;
            fill_reg      <= fill_nxt;
            fill_data     <= fdat_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            mem_wr        <= wr_nxt;
            mem_addr      <= addr_nxt;
            mem_writedata <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_copy_dma.sv
// Bench for dmem_copy_dma: word memory model, write scoreboard, vector table and corner sequences.
module tb_dmem_copy_dma;
    localparam int unsigned AW = 14;
    localparam int unsigned MW = 1 << AW;

    logic        clk, reset, start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] length;
    logic [31:0] mem_readdata;
    logic        busy, done, mem_wr;
    logic [31:0] mem_addr, mem_writedata;
`ifdef DMA_FILL_EN
    logic        fill_mode;
    logic [31:0] fill_value;
`endif

    dmem_copy_dma #(.Abits(14), .Lbits(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
`ifdef DMA_FILL_EN
        .fill_mode(fill_mode), .fill_value(fill_value),
`endif
        .mem_readdata(mem_readdata), .busy(busy), .done(done), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_writedata(mem_writedata)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { string name; logic [31:0] src; logic [31:0] dst; int len; int done_off; } vec_t;

    logic [31:0] dmem    [MW];
    logic [31:0] ref_mem [MW];
    wr_t         exp_q   [$];
    int checks = 0, failures = 0;
    int ecount = 0, busy_total = 0, wr_total = 0, done_total = 0, done_cyc = 0;
    int ks = 0, w0 = 0, b0 = 0, d0 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) ecount++;

    assign mem_readdata = dmem[mem_addr[AW-1:0]];
    always @(posedge clk) if (mem_wr) dmem[mem_addr[AW-1:0]] <= mem_writedata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (busy) begin
            busy_total++;
            chk("addr_hi_zero", 32'(mem_addr[31:AW]), 32'd0);
        end
        if (done) begin
            done_total++;
            done_cyc = ecount;
        end
        if (mem_wr) begin
            wr_total++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_writedata, e.data);
            end
        end
    end

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            logic [AW-1:0] sa, da;
            sa = AW'(s + 32'(i));
            da = AW'(d + 32'(i));
            e.addr = 32'(da);
            e.data = ref_mem[sa];
            exp_q.push_back(e);
            ref_mem[da] = ref_mem[sa];
        end
    endtask

    task automatic drive_start(input logic [31:0] s, input logic [31:0] d, input int len);
        @(negedge clk);
        w0 = wr_total; b0 = busy_total; d0 = done_total;
        src_addr = s; dst_addr = d; length = 16'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ks = ecount;
    endtask

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input int len, input int nexp);
`ifdef DMA_FILL_EN
        fill_mode = 1'b0;
`endif
        push_copy(s, d, nexp);
        drive_start(s, d, len);
    endtask

    task automatic wait_done(input string name, input int off, input int nwr, input int nbusy);
        int t;
        t = 0;
        while (done_total == d0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (done_total == d0) begin
            chk({name, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_done_cycle"}, 32'(done_cyc - ks), 32'(off));
        end
        @(negedge clk);
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
        chk({name, "_done_pulse_len"}, 32'(done), 32'd0);
        chk({name, "_idle_addr"}, mem_addr, 32'd0);
        chk({name, "_writes"}, 32'(wr_total - w0), 32'(nwr));
        chk({name, "_busy_cycles"}, 32'(busy_total - b0), 32'(nbusy));
        chk({name, "_done_count"}, 32'(done_total - d0), 32'd1);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"copy4",     32'h10,  32'h20,   4, 8};
        vecs[1] = '{"zero_len",  32'h100, 32'h200,  0, 0};
        vecs[2] = '{"wrap",      32'h10,  32'h3FFF, 2, 4};
        vecs[3] = '{"smear",     32'h50,  32'h52,   3, 6};
        vecs[4] = '{"single",    32'h300, 32'h400,  1, 2};

        for (int i = 0; i < MW; i++) begin
            dmem[i]    <= 32'h5A00_0000 | 32'(i);
            ref_mem[i]  = 32'h5A00_0000 | 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            dmem[16 + i]    <= 32'hA0 + 32'(i);
            ref_mem[16 + i]  = 32'hA0 + 32'(i);
        end

        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
`ifdef DMA_FILL_EN
        fill_mode = 1'b0; fill_value = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_writedata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            start_xfer(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].len);
            wait_done(vecs[i].name, vecs[i].done_off, vecs[i].len,
                      (vecs[i].len == 0) ? 1 : vecs[i].done_off + 1);
        end
        chk("copy4_dst0", dmem[32'h20], 32'hA0);
        chk("copy4_dst3", dmem[32'h23], 32'hA3);
        chk("wrap_low", dmem[0], 32'hA1);

        // Start pulsed mid-transfer with a different destination must be ignored.
        start_xfer(32'h10, 32'h20, 4, 4);
        repeat (3) @(negedge clk);
        dst_addr = 32'h40; src_addr = 32'h0; length = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 8, 4, 9);
        chk("busy_start_no40", dmem[32'h40], 32'h5A00_0040);

        // Reset in cycle k+5 (after two writes): no further writes, no done.
        start_xfer(32'h10, 32'h70, 4, 2);
        while (ecount < ks + 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        repeat (12) @(negedge clk);
        chk("rst_mid_writes", 32'(wr_total - w0), 32'd2);
        chk("rst_mid_no_done", 32'(done_total - d0), 32'd0);
        chk("rst_mid_w71", dmem[32'h71], 32'hA1);
        chk("rst_mid_w72", dmem[32'h72], 32'h5A00_0072);
        chk("rst_mid_queue", 32'(exp_q.size()), 32'd0);

        // A fresh transfer after reset still works.
        start_xfer(32'h12, 32'h80, 2, 2);
        wait_done("post_reset", 4, 2, 5);

`ifdef DMA_FILL_EN
        fill_mode = 1'b1; fill_value = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            wr_t e;
            e.addr = 32'h30 + 32'(i);
            e.data = 32'hDEAD_BEEF;
            exp_q.push_back(e);
            ref_mem[32'h30 + i] = 32'hDEAD_BEEF;
        end
        drive_start(32'h10, 32'h30, 3);
        wait_done("fill3", 3, 3, 4);
        chk("fill_dst2", dmem[32'h32], 32'hDEAD_BEEF);
        fill_mode = 1'b0;
`endif

        begin
            int bad;
            bad = 0;
            for (int i = 0; i < MW; i++) if (dmem[i] !== ref_mem[i]) bad++;
            chk("final_mem_mismatches", 32'(bad), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
